// File: rtl/usb_tx_fifo.sv
// usb_tx_fifo: byte FIFO between the host side and the USB transmitter.
// The head byte is presented first-word-fall-through, so the transmitter
// samples tx_packet_data in the same cycle it pulses get_tx_packet_data.
// Errors are sticky until clear or reset.
module usb_tx_fifo #(
  parameter int DEPTH = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       store_tx_data,
  input  logic [7:0] tx_data,
  input  logic       get_tx_packet_data,
  output logic [7:0] tx_packet_data,
  output logic [6:0] buffer_occupancy,
  output logic       full,
  output logic       empty,
  output logic       overflow_err,
  output logic       underflow_err
);

  // DEPTH is a power of two, so the pointers wrap naturally at AW bits.
  localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] FULL_COUNT = 7'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [6:0]    r_count;
  logic          r_overflow;
  logic          r_underflow;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;
  logic w_overflow_hit;
  logic w_underflow_hit;

  // Handshake qualification. A pop frees a slot in the same edge, so a push
  // against a full buffer is accepted when it is paired with a valid pop.
  always_comb begin
    w_full          = (r_count == FULL_COUNT);
    w_empty         = (r_count == 7'd0);
    w_pop_ok        = get_tx_packet_data && !w_empty;
    w_push_ok       = store_tx_data && (!w_full || w_pop_ok);
    w_overflow_hit  = store_tx_data && w_full && !get_tx_packet_data;
    w_underflow_hit = get_tx_packet_data && w_empty;
  end

  // Byte storage; no reset needed because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push_ok && !clear) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // Pointers, occupancy and sticky error flags; clear overrides any transfer.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= 7'd0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= 7'd0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 7'd1;
        2'b01:   r_count <= r_count - 7'd1;
        default: r_count <= r_count;
      endcase
      if (w_overflow_hit) begin
        r_overflow <= 1'b1;
      end
      if (w_underflow_hit) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Output drive; the head byte reads as zero whenever nothing is stored.
  always_comb begin
    tx_packet_data   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    buffer_occupancy = r_count;
    full             = w_full;
    empty            = w_empty;
    overflow_err     = r_overflow;
    underflow_err    = r_underflow;
  end

endmodule

// File: doc/usb_tx_fifo.md
USB_TX_FIFO -- requirements
Module: usb_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning number of byte entries; legal values are powers of two, 2 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port clear, input, 1 bit: synchronous flush of all entries.
REQ-005 The block SHALL have port store_tx_data, input, 1 bit: push strobe from the host side.
REQ-006 The block SHALL have port tx_data, input, 8 bits: byte pushed when store_tx_data=1.
REQ-007 The block SHALL have port get_tx_packet_data, input, 1 bit: pop strobe from the transmitter.
REQ-008 The block SHALL have port tx_packet_data, output, 8 bits: head byte, first-word-fall-through.
REQ-009 The block SHALL have port buffer_occupancy, output, 7 bits: number of valid entries, 0 to DEPTH.
REQ-010 The block SHALL have ports full and empty, outputs, 1 bit each: occupancy==DEPTH and occupancy==0.
REQ-011 The block SHALL have ports overflow_err and underflow_err, outputs, 1 bit each: sticky error flags.

Function
REQ-012 Storage SHALL be a circular buffer of DEPTH bytes with a write pointer, a read pointer (log2(DEPTH) bits each, wrapping DEPTH-1 to 0) and a registered 7-bit occupancy counter.
REQ-013 tx_packet_data SHALL combinationally equal mem[rd_ptr] when not empty, and 8'h00 when empty.
REQ-014 Push: when store_tx_data=1 and not full, tx_data SHALL be written at wr_ptr, wr_ptr SHALL increment, and occupancy SHALL increment at that edge.
REQ-015 Pop: when get_tx_packet_data=1 and not empty, rd_ptr SHALL increment and occupancy SHALL decrement at that edge; the byte consumed is the tx_packet_data value in the strobe cycle.
REQ-016 The transmitter samples tx_packet_data in the same cycle it asserts get_tx_packet_data, so pop latency SHALL be zero cycles and the next byte SHALL appear the cycle after.
REQ-017 Push latency: a byte written into an empty buffer SHALL appear on tx_packet_data and raise buffer_occupancy in the cycle after the push edge.
REQ-018 Simultaneous push and pop, 0<occupancy<DEPTH: both SHALL occur and occupancy SHALL be unchanged.
REQ-019 Simultaneous push and pop while full: both SHALL occur, occupancy SHALL stay DEPTH, and overflow_err SHALL NOT be set.
REQ-020 Simultaneous push and pop while empty: the push SHALL occur, the pop SHALL be ignored, underflow_err SHALL be set, and occupancy SHALL become 1.
REQ-021 A push while full without a pop SHALL be discarded, leave memory and pointers unchanged, and set overflow_err.
REQ-022 A pop while empty SHALL be ignored and set underflow_err.
REQ-023 clear=1 SHALL, at the next edge, zero both pointers, occupancy, overflow_err and underflow_err, overriding any push or pop in that cycle.
REQ-024 Error flags SHALL stay set until clear or reset.
REQ-025 buffer_occupancy SHALL never exceed DEPTH or wrap below 0.

Reset
REQ-026 While n_rst=0, pointers, occupancy and error flags SHALL be 0 immediately, regardless of clk, giving buffer_occupancy=0, empty=1, full=0, tx_packet_data=8'h00.
REQ-027 Memory contents need not be reset; no stale byte SHALL ever be visible on tx_packet_data after reset.
REQ-028 Reset asserted mid-transfer SHALL discard all entries; the first push after reset release SHALL land at entry 0.

Verification
REQ-029 Scenario: reset, then push 8'hA5, 8'h3C -> occupancy 2, tx_packet_data=A5; pop -> tx_packet_data=3C, occupancy 1; pop -> empty=1, data 00.
REQ-030 Scenario: push 64 bytes 0..63 -> full=1, occupancy 64; push 8'hFF -> overflow_err=1, occupancy 64; 64 pops return 0..63 in order.
REQ-031 Scenario: pop while empty -> underflow_err=1, occupancy 0; simultaneous push 8'h11 and pop when empty -> occupancy 1, head 11.
REQ-032 Scenario: full buffer, simultaneous push 8'h77 and pop -> occupancy 64, no overflow; the 77 is returned as the last byte.
REQ-033 Scenario: 100 push/pop pairs across pointer wrap at occupancy 10 -> byte order preserved, occupancy stays 10.
REQ-034 Scenario: occupancy 5 with errors set, assert clear with a concurrent push -> next cycle occupancy 0, flags 0; assert n_rst=0 mid-stream -> immediate occupancy 0.
